// File: rtl/color_manager_response_encoder_if.sv
// Bundle between the configuration manager, the response encoder and the UART TX FIFO write port.
// The master drives events and the FIFO Full flag; the slave (encoder) drives the FIFO write side.
interface color_manager_response_encoder_if #(
   parameter int UART_DATA_WIDTH           = 8,
   parameter int CONFIG_NOTIFICATION_WIDTH = 4,
   parameter int CONFIG_ERROR_WIDTH        = 4,
   parameter int CONFIG_STATUS_WIDTH       = 8
);
   logic [CONFIG_NOTIFICATION_WIDTH-1:0] Config_Notification;
   logic                                 Config_Notification_Valid;
   logic [CONFIG_ERROR_WIDTH-1:0]        Config_Error;
   logic                                 Error_Valid;
   logic [CONFIG_STATUS_WIDTH-1:0]       Config_Status;
   logic                                 Full;
   logic [UART_DATA_WIDTH-1:0]           TXD_Data;
   logic                                 Wr_En;
   logic                                 Busy;
   logic                                 Drop;

   modport master (
      output Config_Notification, Config_Notification_Valid, Config_Error, Error_Valid,
             Config_Status, Full,
      input  TXD_Data, Wr_En, Busy, Drop
   );

   modport slave (
      input  Config_Notification, Config_Notification_Valid, Config_Error, Error_Valid,
             Config_Status, Full,
      output TXD_Data, Wr_En, Busy, Drop
   );
endinterface

// File: rtl/color_manager_response_encoder.sv
// Queues config notification/error events and serializes each as a byte frame into the UART TX FIFO.
// Define RESPONSE_CRC_EN to append a third byte (byte0 ^ byte1) to every frame.
module color_manager_response_encoder #(
   parameter int UART_DATA_WIDTH           = 8,
   parameter int CONFIG_NOTIFICATION_WIDTH = 4,
   parameter int CONFIG_ERROR_WIDTH        = 4,
   parameter int CONFIG_STATUS_WIDTH       = 8,
   parameter int EVT_DEPTH                 = 4
) (
   input  logic                            Clk,
   input  logic                            Rst,
   color_manager_response_encoder_if.slave bus
);
   localparam int CW = CONFIG_NOTIFICATION_WIDTH;
   localparam int SW = CONFIG_STATUS_WIDTH;
   localparam int EW = 1 + CW + SW;
   localparam int AW = $clog2(EVT_DEPTH);
   localparam logic [AW:0] DEPTH_C = EVT_DEPTH[AW:0];
   localparam logic [AW:0] ONE_C   = 1;

   typedef enum logic [2:0] {
      IDLE, HDR_GAP, STAT, STAT_GAP
`ifdef RESPONSE_CRC_EN
      , CRC, CRC_GAP
`endif
   } state_t;

   state_t                     state_q;
   logic [EW-1:0]              mem_q [EVT_DEPTH];
   logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
   logic [AW:0]                cnt_q, cnt_d;
   logic [1:0]                 seq_q;
   logic [UART_DATA_WIDTH-1:0] txd_q;
   logic                       wr_en_q, busy_q, drop_q;

   logic                          ev, both, q_full, push, pop, drop_d, start, to_idle, busy_d;
   logic [CONFIG_ERROR_WIDTH-1:0] err_code;
   logic [EW-1:0]                 entry_in, head;
   logic [UART_DATA_WIDTH-1:0]    byte0, byte1;

   assign err_code = bus.Config_Error;
   assign ev       = bus.Error_Valid | bus.Config_Notification_Valid;
   assign both     = bus.Error_Valid & bus.Config_Notification_Valid;
   assign entry_in = bus.Error_Valid ? {1'b1, err_code, bus.Config_Status}
                                     : {1'b0, bus.Config_Notification, bus.Config_Status};
   assign q_full   = (cnt_q == DEPTH_C);

   // The entry leaves the queue only with the last byte of its frame.
`ifdef RESPONSE_CRC_EN
   assign pop = (state_q == CRC) && !bus.Full;
`else
   assign pop = (state_q == STAT) && !bus.Full;
`endif
   assign push   = ev & (!q_full | pop);
   assign drop_d = both | (ev & q_full & !pop);
   assign start  = (cnt_q != '0) && !bus.Full;

   assign head  = mem_q[rd_ptr_q];
   assign byte0 = {1'b1, head[EW-1], seq_q, head[SW +: CW]};
   assign byte1 = head[SW-1:0];

   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + ONE_C;
      else if (!push && pop)
         cnt_d = cnt_q - ONE_C;
   end

   always_comb begin
      to_idle = 1'b0;
      case (state_q)
         IDLE:     to_idle = !start;
`ifdef RESPONSE_CRC_EN
         CRC_GAP:  to_idle = 1'b1;
`else
         STAT_GAP: to_idle = 1'b1;
`endif
         default:  to_idle = 1'b0;
      endcase
      busy_d = !to_idle || (cnt_d != '0);
   end

   always_ff @(posedge Clk) begin
      if (push)
         mem_q[wr_ptr_q] <= entry_in;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         seq_q    <= '0;
         txd_q    <= '0;
         wr_en_q  <= 1'b0;
         busy_q   <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)
            rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q   <= cnt_d;
         drop_q  <= drop_d;
         busy_q  <= busy_d;
         wr_en_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  wr_en_q <= 1'b1;
                  txd_q   <= byte0;
                  state_q <= HDR_GAP;
               end
            end
            // Full lags a write by one cycle, so every write is followed by a gap.
            HDR_GAP: state_q <= STAT;
            STAT: begin
               if (!bus.Full) begin
                  wr_en_q <= 1'b1;
                  txd_q   <= byte1;
                  state_q <= STAT_GAP;
`ifndef RESPONSE_CRC_EN
                  seq_q   <= seq_q + 2'd1;
`endif
               end
            end
`ifdef RESPONSE_CRC_EN
            STAT_GAP: state_q <= CRC;
            CRC: begin
               if (!bus.Full) begin
                  wr_en_q <= 1'b1;
                  txd_q   <= byte0 ^ byte1;
                  state_q <= CRC_GAP;
                  seq_q   <= seq_q + 2'd1;
               end
            end
            CRC_GAP: state_q <= IDLE;
`else
            STAT_GAP: state_q <= IDLE;
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.TXD_Data = txd_q;
   assign bus.Wr_En    = wr_en_q;
   assign bus.Busy     = busy_q;
   assign bus.Drop     = drop_q;
endmodule

// File: tb/tb_color_manager_response_encoder.sv
// Self-checking bench for color_manager_response_encoder: byte-stream model plus directed timing checks.
`timescale 1ns/1ps
module tb_color_manager_response_encoder;
`ifdef RESPONSE_CRC_EN
   localparam int FB = 3;
`else
   localparam int FB = 2;
`endif

   logic Clk = 1'b0;
   logic Rst;
   always #5 Clk = ~Clk;

   color_manager_response_encoder_if bus ();
   color_manager_response_encoder #(.EVT_DEPTH(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

   int checks = 0;
   int failures = 0;
   logic [7:0] obs[$];
   logic [7:0] exp_q[$];
   int model_seq, exp_drop, drop_cnt, consec_cnt;
   bit prev_wr;

   always @(negedge Clk) begin
      if (Rst) prev_wr = 1'b0;
      else begin
         if (bus.Wr_En) begin
            obs.push_back(bus.TXD_Data);
            if (prev_wr) consec_cnt++;
         end
         if (bus.Drop) drop_cnt++;
         prev_wr = bus.Wr_En;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_inputs();
      bus.Config_Notification_Valid = 1'b0;
      bus.Error_Valid = 1'b0;
   endtask

   task automatic model_push(input bit err, input logic [3:0] code, input logic [7:0] st);
      logic [7:0] b0;
      logic [1:0] s;
      s = model_seq[1:0];
      b0 = {1'b1, err, s, code};
      exp_q.push_back(b0);
      exp_q.push_back(st);
      if (FB == 3) exp_q.push_back(b0 ^ st);
      model_seq = (model_seq + 1) % 4;
   endtask

   task automatic drive_event(input bit nv, input logic [3:0] nc, input bit ev,
                              input logic [3:0] ec, input logic [7:0] st);
      bus.Config_Notification = nc;
      bus.Config_Notification_Valid = nv;
      bus.Config_Error = ec;
      bus.Error_Valid = ev;
      bus.Config_Status = st;
      if (ev) begin
         model_push(1'b1, ec, st);
         if (nv) exp_drop++;
      end else if (nv) model_push(1'b0, nc, st);
   endtask

   task automatic send_event(input bit nv, input logic [3:0] nc, input bit ev,
                             input logic [3:0] ec, input logic [7:0] st);
      drive_event(nv, nc, ev, ec, st);
      @(posedge Clk); #1;
      clear_inputs();
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      clear_inputs();
      bus.Full = 1'b0;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      obs.delete(); exp_q.delete();
      model_seq = 0; exp_drop = 0; drop_cnt = 0; consec_cnt = 0;
   endtask

   task automatic drain(output bit ok);
      int n;
      n = 0;
      while ((obs.size() < exp_q.size() || bus.Busy) && n < 1000) begin
         @(posedge Clk); #1;
         n++;
      end
      repeat (4) begin @(posedge Clk); #1; end
      ok = (n < 1000);
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      clear_inputs();
      bus.Full = 1'b0;
      bus.Config_Notification = '0; bus.Config_Error = '0; bus.Config_Status = '0;
      #1;
      checks++; if (bus.TXD_Data !== 8'h00) begin failures++; $display("FAIL reset_txd: got %h expected 00", bus.TXD_Data); end
      checks++; if (bus.Wr_En !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b expected 0", bus.Wr_En); end
      checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
      checks++; if (bus.Drop !== 1'b0) begin failures++; $display("FAIL reset_drop: got %b expected 0", bus.Drop); end
      do_reset();
   endtask

   task automatic test_basic_frame();
      bit ok;
      do_reset();
      send_event(1'b1, 4'h1, 1'b0, 4'h0, 8'hA5);
      checks++; if (bus.Busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", bus.Busy); end
      checks++; if (bus.Wr_En !== 1'b0) begin failures++; $display("FAIL basic_edge0: got %b expected 0", bus.Wr_En); end
      @(posedge Clk); #1;
      checks++; if (bus.Wr_En !== 1'b1 || bus.TXD_Data !== 8'h81) begin failures++; $display("FAIL basic_byte0: got wr=%b dat=%h expected wr=1 dat=81", bus.Wr_En, bus.TXD_Data); end
      @(posedge Clk); #1;
      checks++; if (bus.Wr_En !== 1'b0 || bus.TXD_Data !== 8'h81) begin failures++; $display("FAIL basic_gap: got wr=%b dat=%h expected wr=0 dat=81", bus.Wr_En, bus.TXD_Data); end
      @(posedge Clk); #1;
      checks++; if (bus.Wr_En !== 1'b1 || bus.TXD_Data !== 8'hA5) begin failures++; $display("FAIL basic_byte1: got wr=%b dat=%h expected wr=1 dat=a5", bus.Wr_En, bus.TXD_Data); end
      if (FB == 3) begin
         repeat (2) @(posedge Clk); #1;
         checks++; if (bus.Wr_En !== 1'b1 || bus.TXD_Data !== 8'h24) begin failures++; $display("FAIL basic_crc: got wr=%b dat=%h expected wr=1 dat=24", bus.Wr_En, bus.TXD_Data); end
      end
      repeat (3) @(posedge Clk); #1;
      send_event(1'b1, 4'h2, 1'b0, 4'h0, 8'h3C);
      drain(ok);
      checks++; if (!ok) begin failures++; $display("FAIL basic_drain: got timeout expected idle"); end
      checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL basic_len: got %0d expected %0d", obs.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL basic_stream[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end end
      if (obs.size() > FB) begin
         checks++; if (obs[FB][5:4] !== 2'd1) begin failures++; $display("FAIL basic_seq1: got %0d expected 1", obs[FB][5:4]); end
      end
      checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL basic_busy_end: got %b expected 0", bus.Busy); end
   endtask

   task automatic test_simultaneous();
      bit ok;
      logic [7:0] st;
      do_reset();
      st = 8'($urandom);
      send_event(1'b1, 4'h1, 1'b1, 4'h3, st);
      checks++; if (bus.Drop !== 1'b1) begin failures++; $display("FAIL simul_drop: got %b expected 1", bus.Drop); end
      @(posedge Clk); #1;
      checks++; if (bus.Drop !== 1'b0) begin failures++; $display("FAIL simul_drop_end: got %b expected 0", bus.Drop); end
      checks++; if (bus.Wr_En !== 1'b1 || bus.TXD_Data !== 8'hC3) begin failures++; $display("FAIL simul_byte0: got wr=%b dat=%h expected wr=1 dat=c3", bus.Wr_En, bus.TXD_Data); end
      drain(ok);
      checks++; if (!ok) begin failures++; $display("FAIL simul_drain: got timeout expected idle"); end
      checks++; if (obs.size() != FB) begin failures++; $display("FAIL simul_len: got %0d expected %0d", obs.size(), FB); end
      else foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL simul_stream[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end end
      checks++; if (drop_cnt != 1) begin failures++; $display("FAIL simul_drop_cnt: got %0d expected 1", drop_cnt); end
   endtask

   task automatic test_overflow();
      bit ok;
      bit err;
      do_reset();
      bus.Full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         err = 1'($urandom);
         if (i < 4) drive_event(!err, 4'($urandom), err, 4'($urandom), 8'($urandom));
         else begin
            bus.Config_Notification_Valid = 1'b1;
            bus.Config_Notification = 4'($urandom);
            exp_drop++;
         end
         @(posedge Clk); #1;
         clear_inputs();
         checks++; if (bus.Drop !== (i == 4)) begin failures++; $display("FAIL ovf_drop[%0d]: got %b expected %b", i, bus.Drop, i == 4); end
      end
      repeat (4) @(posedge Clk); #1;
      checks++; if (obs.size() != 0 || bus.Busy !== 1'b1) begin failures++; $display("FAIL ovf_held: got writes=%0d busy=%b expected writes=0 busy=1", obs.size(), bus.Busy); end
      bus.Full = 1'b0;
      drain(ok);
      checks++; if (!ok) begin failures++; $display("FAIL ovf_drain: got timeout expected idle"); end
      checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL ovf_len: got %0d expected %0d", obs.size(), exp_q.size()); end
      else begin
         foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_stream[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end end
         for (int k = 0; k < 4; k++) begin
            checks++; if (obs[k*FB][5:4] !== 2'(k)) begin failures++; $display("FAIL ovf_seq[%0d]: got %0d expected %0d", k, obs[k*FB][5:4], k); end
         end
      end
      checks++; if (drop_cnt != exp_drop) begin failures++; $display("FAIL ovf_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
   endtask

   task automatic test_full_hdr_gap();
      bit ok;
      logic [7:0] st;
      do_reset();
      st = 8'($urandom);
      send_event(1'b1, 4'($urandom), 1'b0, 4'h0, st);
      @(posedge Clk); #1;
      checks++; if (bus.Wr_En !== 1'b1) begin failures++; $display("FAIL hold_byte0: got %b expected 1", bus.Wr_En); end
      bus.Full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge Clk); #1;
         checks++; if (bus.Wr_En !== 1'b0 || bus.Busy !== 1'b1) begin failures++; $display("FAIL hold_stat[%0d]: got wr=%b busy=%b expected wr=0 busy=1", k, bus.Wr_En, bus.Busy); end
      end
      bus.Full = 1'b0;
      @(posedge Clk); #1;
      checks++; if (bus.Wr_En !== 1'b1 || bus.TXD_Data !== st) begin failures++; $display("FAIL hold_byte1: got wr=%b dat=%h expected wr=1 dat=%h", bus.Wr_En, bus.TXD_Data, st); end
      @(posedge Clk); #1;
      checks++; if (bus.Wr_En !== 1'b0) begin failures++; $display("FAIL hold_after: got %b expected 0", bus.Wr_En); end
      drain(ok);
      checks++; if (!ok) begin failures++; $display("FAIL hold_drain: got timeout expected idle"); end
      checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL hold_len: got %0d expected %0d", obs.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL hold_stream[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      do_reset();
      send_event(1'b0, 4'h0, 1'b1, 4'($urandom), 8'($urandom));
      @(posedge Clk); #1;
      checks++; if (bus.Wr_En !== 1'b1) begin failures++; $display("FAIL rmid_byte0: got %b expected 1", bus.Wr_En); end
      #1 Rst = 1'b1;
      #1;
      checks++; if (bus.TXD_Data !== 8'h00 || bus.Wr_En !== 1'b0 || bus.Busy !== 1'b0 || bus.Drop !== 1'b0)
         begin failures++; $display("FAIL rmid_outputs: got dat=%h wr=%b busy=%b drop=%b expected all 0", bus.TXD_Data, bus.Wr_En, bus.Busy, bus.Drop); end
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;
      obs.delete(); exp_q.delete(); model_seq = 0; drop_cnt = 0; exp_drop = 0;
      repeat (8) @(posedge Clk); #1;
      checks++; if (obs.size() != 0) begin failures++; $display("FAIL rmid_quiet: got %0d writes expected 0", obs.size()); end
      send_event(1'b1, 4'($urandom), 1'b0, 4'h0, 8'($urandom));
      drain(ok);
      checks++; if (!ok) begin failures++; $display("FAIL rmid_drain: got timeout expected idle"); end
      checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL rmid_len: got %0d expected %0d", obs.size(), exp_q.size()); end
      else begin
         foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_stream[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end end
         checks++; if (obs[0][5:4] !== 2'd0) begin failures++; $display("FAIL rmid_seq: got %0d expected 0", obs[0][5:4]); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit exp_wr;
      do_reset();
      for (int k = 0; k <= 8*FB + 2; k++) begin
         if (k < 4) drive_event(1'b1, 4'($urandom), 1'b0, 4'h0, 8'($urandom));
         else clear_inputs();
         @(posedge Clk); #1;
         exp_wr = (k % 2 == 1) && (k <= 8*FB - 1);
         checks++; if (bus.Wr_En !== exp_wr) begin failures++; $display("FAIL b2b_wr[%0d]: got %b expected %b", k, bus.Wr_En, exp_wr); end
      end
      clear_inputs();
      drain(ok);
      checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL b2b_len: got %0d expected %0d", obs.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_stream[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end end
   endtask

   task automatic test_random();
      bit ok;
      int issued, cyc, kind, outstanding;
      do_reset();
      issued = 0; cyc = 0;
      while (issued < 60 && cyc < 4000) begin
         bus.Full = ($urandom_range(0, 3) == 0);
         outstanding = exp_q.size() / FB - obs.size() / FB;
         if (outstanding < 4 && $urandom_range(0, 1) == 1) begin
            kind = $urandom_range(0, 7);
            drive_event(kind != 1, 4'($urandom), kind == 1 || kind == 2, 4'($urandom), 8'($urandom));
            issued++;
         end else clear_inputs();
         @(posedge Clk); #1;
         cyc++;
      end
      clear_inputs();
      bus.Full = 1'b0;
      drain(ok);
      checks++; if (!ok || issued < 60) begin failures++; $display("FAIL rand_drain: got ok=%b issued=%0d expected ok=1 issued=60", ok, issued); end
      checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL rand_len: got %0d expected %0d", obs.size(), exp_q.size()); end
      else foreach (exp_q[i]) begin checks++; if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL rand_stream[%0d]: got %h expected %h", i, obs[i], exp_q[i]); end end
      checks++; if (drop_cnt != exp_drop) begin failures++; $display("FAIL rand_drop_cnt: got %0d expected %0d", drop_cnt, exp_drop); end
      checks++; if (consec_cnt != 0) begin failures++; $display("FAIL rand_consec_wr: got %0d expected 0", consec_cnt); end
      checks++; if (bus.Busy !== 1'b0) begin failures++; $display("FAIL rand_busy_end: got %b expected 0", bus.Busy); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_simultaneous();
      test_overflow();
      test_full_hdr_gap();
      test_reset_mid_frame();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
